alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 149 ++++++++++++++
 tb/tb_alu_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester arbiter that shares one external combinational ALU: IDLE -> EXEC -> RESP.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); default is round-robin.
module alu_arbiter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [1:0][3:0]       req_op,
    input  logic [1:0][WIDTH-1:0] req_a,
    input  logic [1:0][WIDTH-1:0] req_b,
    output logic [3:0]            alu_sel,
    output logic [WIDTH-1:0]      alu_a,
    output logic [WIDTH-1:0]      alu_b,
    input  logic [WIDTH-1:0]      alu_result,
    output logic [1:0]            rsp_valid,
    input  logic [1:0]            rsp_ready,
    output logic [WIDTH-1:0]      rsp_data,
    output logic                  rsp_err
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

    state_e           state_q, state_d;
    logic             idx_q, idx_d;
    logic [3:0]       sel_q, sel_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             ill_q, ill_d;
    logic [1:0]       rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_err_q, rsp_err_d;
    logic             gnt_c;
    logic [3:0]       gnt_op_c;
    logic             gnt_legal_c;

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign gnt_c = ~req_valid[0];
`else
    logic last_q, last_d;

    // Tie goes to the requester not granted last; a lone requester always wins.
    always_comb begin
        gnt_c  = req_valid[1];
        if (&req_valid) begin
            gnt_c = ~last_q;
        end
        last_d = last_q;
        if (state_q == IDLE && (|req_valid)) begin
            last_d = gnt_c;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    assign gnt_op_c = req_op[gnt_c];

    always_comb begin
        case (gnt_op_c)
            OP_AND, OP_OR, OP_ADD, OP_SUB: gnt_legal_c = 1'b1;
            default:                       gnt_legal_c = 1'b0;
        endcase
    end

    // Next-state and datapath; illegal ops are mapped to AND and flagged at accept.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        sel_d       = sel_q;
        a_d         = a_q;
        b_d         = b_q;
        ill_d       = ill_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        req_ready   = 2'b00;
        case (state_q)
            IDLE: begin
                if ((|req_valid) && !rst) begin
                    req_ready = gnt_c ? 2'b10 : 2'b01;
                    idx_d     = gnt_c;
                    sel_d     = gnt_legal_c ? gnt_op_c : OP_AND;
                    a_d       = req_a[gnt_c];
                    b_d       = req_b[gnt_c];
                    ill_d     = ~gnt_legal_c;
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                rsp_data_d  = ill_q ? '0 : alu_result;
                rsp_err_d   = ill_q;
                rsp_valid_d = idx_q ? 2'b10 : 2'b01;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready[idx_q]) begin
                    rsp_valid_d = 2'b00;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= 1'b0;
            sel_q       <= OP_AND;
            a_q         <= '0;
            b_q         <= '0;
            ill_q       <= 1'b0;
            rsp_valid_q <= 2'b00;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            sel_q       <= sel_d;
            a_q         <= a_d;
            b_q         <= b_d;
            ill_q       <= ill_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign alu_sel   = sel_q;
    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with a behavioural model of the shared ALU.
module tb_alu_arbiter;

    localparam int unsigned WIDTH = 32;

    logic                  clk;
    logic                  rst;
    logic [1:0]            req_valid;
    logic [1:0]            req_ready;
    logic [1:0][3:0]       req_op;
    logic [1:0][WIDTH-1:0] req_a;
    logic [1:0][WIDTH-1:0] req_b;
    logic [3:0]            alu_sel;
    logic [WIDTH-1:0]      alu_a;
    logic [WIDTH-1:0]      alu_b;
    logic [WIDTH-1:0]      alu_result;
    logic [1:0]            rsp_valid;
    logic [1:0]            rsp_ready;
    logic [WIDTH-1:0]      rsp_data;
    logic                  rsp_err;

    int n_tests = 0;
    int n_fail  = 0;

    alu_arbiter #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .alu_sel    (alu_sel),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared ALU; unknown selects return a distinctive value so leaks are visible.
    always_comb begin
        case (alu_sel)
            4'b0000: alu_result = alu_a & alu_b;
            4'b0001: alu_result = alu_a | alu_b;
            4'b0010: alu_result = alu_a + alu_b;
            4'b0110: alu_result = alu_a - alu_b;
            default: alu_result = 32'hDEAD_BEEF;
        endcase
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        check_eq({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check_eq({tag, "_rsp_err"},   32'(rsp_err),   32'd0);
        check_eq({tag, "_rsp_data"},  rsp_data,       32'd0);
        check_eq({tag, "_alu_sel"},   32'(alu_sel),   32'd0);
        check_eq({tag, "_alu_a"},     alu_a,          32'd0);
        check_eq({tag, "_alu_b"},     alu_b,          32'd0);
    endtask

    // One transaction from a lone requester r, with bp cycles of response backpressure.
    task automatic run_op(input string tag, input int r, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] exp_sel, input logic [31:0] exp_data,
                          input logic exp_err, input int bp);
        logic [1:0] oh;
        oh = 2'(1 << r);
        @(negedge clk);
        req_valid    = oh;
        req_op[r]    = op;
        req_a[r]     = a;
        req_b[r]     = b;
        rsp_ready    = 2'b00;
        #1 check_eq({tag, "_accept_ready"}, 32'(req_ready), 32'(oh));
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        check_eq({tag, "_exec_sel"},   32'(alu_sel),   32'(exp_sel));
        check_eq({tag, "_exec_a"},     alu_a,          a);
        check_eq({tag, "_exec_b"},     alu_b,          b);
        check_eq({tag, "_exec_valid"}, 32'(rsp_valid), 32'd0);
        @(negedge clk);
        for (int k = 0; k < bp; k++) begin
            rsp_ready = ~oh;
            req_valid = 2'b11;
            #1;
            check_eq({tag, "_bp_valid"}, 32'(rsp_valid), 32'(oh));
            check_eq({tag, "_bp_data"},  rsp_data,       exp_data);
            check_eq({tag, "_bp_ready"}, 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        req_valid = 2'b00;
        rsp_ready = oh;
        #1;
        check_eq({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(oh));
        check_eq({tag, "_rsp_data"},  rsp_data,       exp_data);
        check_eq({tag, "_rsp_err"},   32'(rsp_err),   32'(exp_err));
        @(negedge clk);
        rsp_ready = 2'b00;
        #1 check_eq({tag, "_done_valid"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        logic [1:0] exp_g;
        rst       = 1'b1;
        req_valid = 2'b00;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 2'b00;
        repeat (2) @(negedge clk);
        req_valid = 2'b01;
        #1 check_reset_outputs("reset");
        req_valid = 2'b00;
        @(negedge clk);
        rst = 1'b0;

        // Contention: both requesters valid and always ready for responses.
        req_op[0] = 4'b0000; req_a[0] = 32'h0000_F0F0; req_b[0] = 32'h0000_FF00;
        req_op[1] = 4'b0110; req_a[1] = 32'd9;         req_b[1] = 32'd4;
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        for (int t = 0; t < 4; t++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            exp_g = 2'b01;
`else
            exp_g = (t % 2 == 0) ? 2'b01 : 2'b10;
`endif
            #1 check_eq("cont_grant", 32'(req_ready), 32'(exp_g));
            @(negedge clk);
            #1 check_eq("cont_exec_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
            #1;
            check_eq("cont_rsp_valid", 32'(rsp_valid), 32'(exp_g));
            check_eq("cont_rsp_data", rsp_data, (exp_g == 2'b01) ? 32'h0000_F000 : 32'd5);
            @(negedge clk);
        end
        req_valid = 2'b00;
        rsp_ready = 2'b00;

        run_op("add_5_7",    0, 4'b0010, 32'd5,         32'd7, 4'b0010, 32'd12,        1'b0, 0);
        run_op("or_rq1",     1, 4'b0001, 32'h0F00_0000, 32'h0000_00F0, 4'b0001, 32'h0F00_00F0, 1'b0, 0);
        run_op("sub_bp",     1, 4'b0110, 32'd9,         32'd4, 4'b0110, 32'd5,         1'b0, 4);
        run_op("illegal",    1, 4'b1111, 32'h1234_5678, 32'hFFFF_FFFF, 4'b0000, 32'd0, 1'b1, 0);
        run_op("legal_after",0, 4'b0000, 32'hFFFF_0000, 32'h0F0F_0F0F, 4'b0000, 32'h0F0F_0000, 1'b0, 0);
        run_op("wrap_add",   0, 4'b0010, 32'hFFFF_FFFF, 32'd1, 4'b0010, 32'd0,         1'b0, 0);
        run_op("wrap_sub",   1, 4'b0110, 32'd0,         32'd1, 4'b0110, 32'hFFFF_FFFF, 1'b0, 0);

        // Reset pulsed mid-EXEC discards the op; rq0 then wins a fresh tie.
        @(negedge clk);
        req_op[1] = 4'b0010; req_a[1] = 32'd100; req_b[1] = 32'd23;
        req_op[0] = 4'b0010; req_a[0] = 32'd40;  req_b[0] = 32'd2;
        req_valid = 2'b10;
        #1 check_eq("rstx_accept", 32'(req_ready), 32'b10);
        @(negedge clk);
        req_valid = 2'b00;
        #1 check_eq("rstx_exec_sel", 32'(alu_sel), 32'b0010);
        rst = 1'b1;
        #1 check_reset_outputs("rstx");
        @(negedge clk);
        rst = 1'b0;
        rsp_ready = 2'b11;
        #1 check_eq("rstx_no_rsp0", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        #1 check_eq("rstx_no_rsp1", 32'(rsp_valid), 32'd0);
        rsp_ready = 2'b00;
        req_valid = 2'b11;
        #1 check_eq("rstx_tie", 32'(req_ready), 32'b01);
        @(negedge clk);
        req_valid = 2'b00;
        #1 check_eq("rstx_exec_a", alu_a, 32'd40);
        @(negedge clk);
        rsp_ready = 2'b01;
        #1;
        check_eq("rstx_rsp_valid", 32'(rsp_valid), 32'b01);
        check_eq("rstx_rsp_data", rsp_data, 32'd42);
        @(negedge clk);
        rsp_ready = 2'b00;
        #1 check_eq("rstx_done", 32'(rsp_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
